cache_mem_arbiter: RTL

Shares the single four-banked main memory between the instruction-cache and data-cache controllers. Each controller requests ownership for a whole fill/evict burst. The arbiter grants one owner at a time (round-robin on contention) and forwards that owner's accesses to memory. It returns read data to whichever port issued the read, tracked through a latency pipeline. It sits between the two cache FSMs and the four-bank memory.

---
 rtl/cache_mem_arbiter_if.sv | 44 ++++
 rtl/cache_mem_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_arbiter_if
//  Description : Bundle of the I-cache/D-cache request ports and the shared
//                four-bank memory port handled by cache_mem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cache_mem_arbiter_if;
  // Cache-controller side
  logic        req0, req1;
  logic        rd0, rd1;
  logic        wr0, wr1;
  logic [15:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        ack0, ack1;
  logic        rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        err0, err1;
  // Memory side
  logic [15:0] fm_addr;
  logic [15:0] fm_data_in;
  logic        fm_rd, fm_wr;
  logic [15:0] m_data_out;
  logic [3:0]  m_busy;
  logic        m_err;

  // Arbiter view
  modport master (
    input  req0, req1, rd0, rd1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    input  m_data_out, m_busy, m_err,
    output gnt0, gnt1, ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
    output err0, err1, fm_addr, fm_data_in, fm_rd, fm_wr
  );

  // Environment view (cache controllers plus memory)
  modport slave (
    output req0, req1, rd0, rd1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    output m_data_out, m_busy, m_err,
    input  gnt0, gnt1, ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
    input  err0, err1, fm_addr, fm_data_in, fm_rd, fm_wr
  );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_arbiter
//  Description : Burst-granular round-robin arbiter between the instruction
//                and data cache controllers for one four-bank memory. Read
//                data is steered back by a tag pipeline, not by the grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
  parameter int RD_LAT = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,     // synchronous, active low
  cache_mem_arbiter_if.master bus_io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [RD_LAT-1:0] tag_vld_q;
  logic [RD_LAT-1:0] tag_port_q;

  logic w_own0, w_own1;
  logic w_busy0, w_busy1;
  logic w_rd_accept, w_rd_port;
  logic w_ret_vld, w_ret_port;

  // State and round-robin history registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next ownership: owner holds until it drops req, then direct handoff
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (bus_io.req0 && bus_io.req1) begin
          // Tie goes to whoever did not win the previous tie
          if (last_owner_q) begin
            state_d      = OWN0;
            last_owner_d = 1'b0;
          end else begin
            state_d      = OWN1;
            last_owner_d = 1'b1;
          end
        end else if (bus_io.req0) begin
          state_d = OWN0;
        end else if (bus_io.req1) begin
          state_d = OWN1;
        end
      end
      OWN0: if (!bus_io.req0) state_d = bus_io.req1 ? OWN1 : IDLE;
      OWN1: if (!bus_io.req1) state_d = bus_io.req0 ? OWN0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus_io.gnt0 = (state_q == OWN0);
  assign bus_io.gnt1 = (state_q == OWN1);
  assign w_own0      = bus_io.gnt0 & bus_io.req0;
  assign w_own1      = bus_io.gnt1 & bus_io.req1;
  assign w_busy0     = bus_io.m_busy[bus_io.addr0[2:1]];
  assign w_busy1     = bus_io.m_busy[bus_io.addr1[2:1]];

  // Forward the active owner's access; strobe stays up while the bank is busy
  always_comb begin
    bus_io.fm_addr    = '0;
    bus_io.fm_data_in = '0;
    bus_io.fm_rd      = 1'b0;
    bus_io.fm_wr      = 1'b0;
    if (w_own0) begin
      bus_io.fm_addr    = bus_io.addr0;
      bus_io.fm_data_in = bus_io.wdata0;
      bus_io.fm_rd      = bus_io.rd0 & ~bus_io.wr0;
      bus_io.fm_wr      = bus_io.wr0 & ~bus_io.rd0;
    end else if (w_own1) begin
      bus_io.fm_addr    = bus_io.addr1;
      bus_io.fm_data_in = bus_io.wdata1;
      bus_io.fm_rd      = bus_io.rd1 & ~bus_io.wr1;
      bus_io.fm_wr      = bus_io.wr1 & ~bus_io.rd1;
    end
  end

  // Acceptance and error reporting; rd&wr together is illegal and never issued
  always_comb begin
    bus_io.ack0 = w_own0 & (bus_io.rd0 ^ bus_io.wr0) & ~w_busy0;
    bus_io.ack1 = w_own1 & (bus_io.rd1 ^ bus_io.wr1) & ~w_busy1;
    bus_io.err0 = (w_own0 & bus_io.rd0 & bus_io.wr0) | (bus_io.gnt0 & bus_io.m_err);
    bus_io.err1 = (w_own1 & bus_io.rd1 & bus_io.wr1) | (bus_io.gnt1 & bus_io.m_err);
  end

  // An ack implies exactly one of rd/wr, so ack&rd is an accepted read
  assign w_rd_accept = (bus_io.ack0 & bus_io.rd0) | (bus_io.ack1 & bus_io.rd1);
  assign w_rd_port   = bus_io.ack1 & bus_io.rd1;

  // Read tag pipeline: one stage per cycle, cleared on reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_vld_q  <= '0;
      tag_port_q <= '0;
    end else begin
      tag_vld_q[0]  <= w_rd_accept;
      tag_port_q[0] <= w_rd_port;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_vld_q[k]  <= tag_vld_q[k-1];
        tag_port_q[k] <= tag_port_q[k-1];
      end
    end
  end

  assign w_ret_vld  = tag_vld_q[RD_LAT-1];
  assign w_ret_port = tag_port_q[RD_LAT-1];

  // Return data to the port that issued the read
  always_comb begin
    bus_io.rvalid0 = w_ret_vld & ~w_ret_port;
    bus_io.rvalid1 = w_ret_vld &  w_ret_port;
    bus_io.rdata0  = bus_io.rvalid0 ? bus_io.m_data_out : 16'h0000;
    bus_io.rdata1  = bus_io.rvalid1 ? bus_io.m_data_out : 16'h0000;
  end

endmodule
`default_nettype wire
